// File: rtl/data_mem_sequencer.sv
// Data-side memory initiator: splits one scalar/unit-stride vector load/store into per-element
// memory transactions. Optional watchdog on the completion wait enabled by DATA_MEM_SEQ_TIMEOUT_EN.
module data_mem_sequencer #(
    parameter int unsigned ADDR_WIDTH       = 17,
    parameter int unsigned DATA_LEN         = 32,
    parameter int unsigned BYTE_SIZE        = 8,
    parameter int unsigned VECTOR_SIZE      = 8,
    parameter int unsigned ENTRY_INDEX_SIZE = 3,
    parameter int unsigned TIMEOUT_CYCLES   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic [2:0]                        req_data_type,
    input  logic [ENTRY_INDEX_SIZE:0]         req_length,
    input  logic [VECTOR_SIZE*DATA_LEN-1:0]   req_wdata,
    output logic                              resp_valid,
    output logic                              resp_error,
    output logic [VECTOR_SIZE*DATA_LEN-1:0]   resp_rdata,
    output logic [1:0]                        d_cache_mem_vis_signal,
    output logic [ADDR_WIDTH-1:0]             d_cache_mem_vis_addr,
    output logic [ENTRY_INDEX_SIZE:0]         length,
    output logic [DATA_LEN-1:0]               written_data,
    output logic [2:0]                        data_type,
    input  logic [DATA_LEN-1:0]               mem_data,
    input  logic [1:0]                        mem_status
);

    localparam int unsigned LEN_W = ENTRY_INDEX_SIZE + 1;
    localparam int unsigned VEC_W = VECTOR_SIZE * DATA_LEN;

    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    localparam logic [1:0] MEM_RESTING       = 2'd0;
    localparam logic [1:0] MEM_DATA_FINISHED = 2'd1;
    localparam logic [1:0] MEM_INST_FINISHED = 2'd2;

    localparam logic [2:0] ONE_BYTE  = 3'd0;
    localparam logic [2:0] TWO_BYTE  = 3'd1;
    localparam logic [2:0] FOUR_BYTE = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Element size in bytes; 0 marks an illegal data type.
    function automatic logic [3:0] elem_size(input logic [2:0] dt);
        case (dt)
            ONE_BYTE:  elem_size = 4'd1;
            TWO_BYTE:  elem_size = 4'd2;
            FOUR_BYTE: elem_size = 4'd4;
            default:   elem_size = 4'd0;
        endcase
    endfunction

    function automatic int unsigned pad_bits(input logic [2:0] dt);
        pad_bits = DATA_LEN - BYTE_SIZE * 32'(elem_size(dt));
    endfunction

    // Stores leave the bus left-aligned: first memory byte in the top byte lane.
    function automatic logic [DATA_LEN-1:0] store_align(input logic [DATA_LEN-1:0] e,
                                                         input logic [2:0] dt);
        store_align = e << pad_bits(dt);
    endfunction

    function automatic logic [DATA_LEN-1:0] load_extract(input logic [DATA_LEN-1:0] w,
                                                          input logic [2:0] dt);
        load_extract = w >> pad_bits(dt);
    endfunction

    state_t                      state, state_n;
    logic [ENTRY_INDEX_SIZE-1:0] index, index_n;
    logic                        write_q, write_n;
    logic [VEC_W-1:0]            wdata_q, wdata_n;
    logic                        err_q, err_n;
    logic                        req_ready_n;
    logic                        resp_valid_n, resp_error_n;
    logic [VEC_W-1:0]            rdata_n;
    logic [1:0]                  signal_n;
    logic [ADDR_WIDTH-1:0]       vis_addr_n;
    logic [LEN_W-1:0]            length_n;
    logic [DATA_LEN-1:0]         written_n;
    logic [2:0]                  dtype_n;
    logic                        last_elem;
    logic                        accept_legal;

`ifdef DATA_MEM_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt, to_cnt_n;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        index_n      = index;
        write_n      = write_q;
        wdata_n      = wdata_q;
        err_n        = err_q;
        resp_valid_n = 1'b0;
        resp_error_n = 1'b0;
        rdata_n      = resp_rdata;
        signal_n     = MEM_NOP;
        vis_addr_n   = d_cache_mem_vis_addr;
        length_n     = length;
        written_n    = written_data;
        dtype_n      = data_type;
        accept_legal = elem_size(req_data_type) != 4'd0;
        // Length above VECTOR_SIZE is clamped so the index can never run past the last slot.
        last_elem    = ({1'b0, index} == length - LEN_W'(1)) ||
                       (index == ENTRY_INDEX_SIZE'(VECTOR_SIZE - 1));
`ifdef DATA_MEM_SEQ_TIMEOUT_EN
        to_cnt_n     = to_cnt;
`endif

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    write_n    = req_write;
                    wdata_n    = req_wdata;
                    length_n   = req_length;
                    dtype_n    = req_data_type;
                    vis_addr_n = req_addr;
                    rdata_n    = '0;
                    index_n    = '0;
                    err_n      = !accept_legal;
                    if (req_length == '0 || !accept_legal) begin
                        state_n = S_DONE;
                    end else begin
                        state_n  = S_ISSUE;
                        signal_n = req_write ? MEM_WRITE : MEM_READ;
                        if (req_write) begin
                            written_n = store_align(req_wdata[DATA_LEN-1:0], req_data_type);
                        end
                    end
                end
            end

            S_ISSUE: begin
                state_n = S_WAIT;
`ifdef DATA_MEM_SEQ_TIMEOUT_EN
                to_cnt_n = '0;
`endif
            end

            // Bus is held at NOP here so the next status can only be a fresh completion.
            S_WAIT: begin
                case (mem_status)
                    MEM_DATA_FINISHED: begin
                        if (!write_q) begin
                            rdata_n[32'(index)*DATA_LEN +: DATA_LEN] =
                                load_extract(mem_data, data_type);
                        end
                        if (last_elem) begin
                            state_n = S_DONE;
                        end else begin
                            index_n    = index + ENTRY_INDEX_SIZE'(1);
                            vis_addr_n = d_cache_mem_vis_addr + ADDR_WIDTH'(elem_size(data_type));
                            state_n    = S_ISSUE;
                            signal_n   = write_q ? MEM_WRITE : MEM_READ;
                            if (write_q) begin
                                written_n = store_align(
                                    wdata_q[32'(index_n)*DATA_LEN +: DATA_LEN], data_type);
                            end
                        end
                    end
                    MEM_RESTING, MEM_INST_FINISHED: ;
                    default: ;
                endcase
`ifdef DATA_MEM_SEQ_TIMEOUT_EN
                if (mem_status != MEM_DATA_FINISHED) begin
                    if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_n = S_DONE;
                        err_n   = 1'b1;
                    end else begin
                        to_cnt_n = to_cnt + TO_W'(1);
                    end
                end
`endif
            end

            S_DONE: begin
                state_n      = S_IDLE;
                resp_valid_n = 1'b1;
                resp_error_n = err_q;
            end

            default: state_n = S_IDLE;
        endcase

        req_ready_n = (state_n == S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= S_IDLE;
            index                  <= '0;
            write_q                <= 1'b0;
            wdata_q                <= '0;
            err_q                  <= 1'b0;
            req_ready              <= 1'b1;
            resp_valid             <= 1'b0;
            resp_error             <= 1'b0;
            resp_rdata             <= '0;
            d_cache_mem_vis_signal <= MEM_NOP;
            d_cache_mem_vis_addr   <= '0;
            length                 <= '0;
            written_data           <= '0;
            data_type              <= '0;
`ifdef DATA_MEM_SEQ_TIMEOUT_EN
            to_cnt                 <= '0;
`endif
        end else begin
            state                  <= state_n;
            index                  <= index_n;
            write_q                <= write_n;
            wdata_q                <= wdata_n;
            err_q                  <= err_n;
            req_ready              <= req_ready_n;
            resp_valid             <= resp_valid_n;
            resp_error             <= resp_error_n;
            resp_rdata             <= rdata_n;
            d_cache_mem_vis_signal <= signal_n;
            d_cache_mem_vis_addr   <= vis_addr_n;
            length                 <= length_n;
            written_data           <= written_n;
            data_type              <= dtype_n;
`ifdef DATA_MEM_SEQ_TIMEOUT_EN
            to_cnt                 <= to_cnt_n;
`endif
        end
    end

endmodule

// File: doc/data_mem_sequencer.md
Name: data_mem_sequencer

Overview:
- Data-side initiator for the main memory port, which is 4-byte bandwidth with a one-cycle registered response.
- Accepts one scalar or unit-stride vector load/store from the LSU, splits it into one memory transaction per element, and drives the d-cache request signals.
- Collects completions through mem_status and returns the assembled read data or a write acknowledge to the LSU.

Parameters:
ADDR_WIDTH, 17, byte address width
DATA_LEN, 32, memory word / element slot width
BYTE_SIZE, 8, bits per byte
VECTOR_SIZE, 8, max elements per request
ENTRY_INDEX_SIZE, 3, log2(VECTOR_SIZE)
TIMEOUT_CYCLES, 16, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  LSU request strobe
req_ready  out  1  high only in IDLE
req_write  in  1  1=store, 0=load
req_addr  in  ADDR_WIDTH  base byte address
req_data_type  in  3  ONE_BYTE/TWO_BYTE/FOUR_BYTE
req_length  in  ENTRY_INDEX_SIZE+1  element count, 0..VECTOR_SIZE
req_wdata  in  VECTOR_SIZE*DATA_LEN  store elements; element i in bits [i*DATA_LEN +: DATA_LEN], right-justified
resp_valid  out  1  one-cycle completion pulse
resp_error  out  1  qualified by resp_valid
resp_rdata  out  VECTOR_SIZE*DATA_LEN  load elements, same packing
d_cache_mem_vis_signal  out  2  MEM_NOP/MEM_READ/MEM_WRITE
d_cache_mem_vis_addr  out  ADDR_WIDTH  element address
length  out  ENTRY_INDEX_SIZE+1  latched req_length
written_data  out  DATA_LEN  store element, left-aligned (first byte in [31:24])
data_type  out  3  latched req_data_type
mem_data  in  DATA_LEN  read word, memory byte order (addr in [31:24])
mem_status  in  2  MEM_RESTING/MEM_DATA_FINISHED/MEM_INST_FINISHED

Behaviour:
- Signal and status encodings come from the shared defines file.
- Reset values:
  - FSM state IDLE; req_ready=1.
  - resp_valid=0, resp_error=0, resp_rdata=0.
  - d_cache_mem_vis_signal=MEM_NOP; d_cache_mem_vis_addr, length, written_data, data_type all 0.
  - Element index=0.
- Reset mid-operation: the request is abandoned with no resp_valid. The signal is MEM_NOP from the next edge.
- Element size: ONE_BYTE=1, TWO_BYTE=2, FOUR_BYTE=4.
- Element i address = base + i*size, truncated to ADDR_WIDTH. Wrap-around modulo 2^ADDR_WIDTH is legal.
- States:
  - IDLE: on req_valid, latch all req_* fields, clear resp_rdata and the index.
    - length==0 or illegal data_type -> DONE, with resp_error=1 only for an illegal data_type.
    - Otherwise -> ISSUE.
  - ISSUE (1 cycle): drive MEM_READ or MEM_WRITE with the element address.
    - Write: written_data = element << (DATA_LEN - 8*size).
    - Next state WAIT.
  - WAIT: drive MEM_NOP (this guarantees the next status reads RESTING, never a stale finish).
    - On mem_status==MEM_DATA_FINISHED, a load captures mem_data[31 -: 8*size] zero-extended into slot index; bytes are not reordered.
    - Then, if index==length-1 -> DONE, else index++ -> ISSUE.
    - MEM_RESTING and MEM_INST_FINISHED: remain in WAIT.
  - DONE (1 cycle): resp_valid=1 -> IDLE.
- resp_rdata holds its value until the next accepted request.
- Latency: 2 cycles per element plus 1 cycle for DONE. A request is accepted at edge T; resp_valid is high in cycle T+2*length+1.
- req_valid outside IDLE is ignored (req_ready=0). The LSU holds the request until it sees ready.
- Only one outstanding memory transaction exists at any time.

Optional Feature:
- Macro: DATA_MEM_SEQ_TIMEOUT_EN.
- With the macro:
  - A counter is cleared on entry to WAIT and incremented each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without MEM_DATA_FINISHED -> DONE with resp_error=1.
  - Already-captured load slots are kept; remaining slots are 0.
- Without the macro: WAIT waits indefinitely, and resp_error is set only for an illegal data_type.

Test Plan:
- Reset asserted while in WAIT -> next cycle signal=MEM_NOP, req_ready=1, no resp_valid.
- Load FOUR_BYTE, addr 0x1000, length 1, memory bytes 0x11 0x22 0x33 0x44:
  - ISSUE addr 0x1000, then signal=MEM_NOP, mem_status=MEM_DATA_FINISHED.
  - slot0 = 0x11223344; resp_valid 3 cycles after acceptance.
- Store TWO_BYTE, addr 0x0FFE, length 3, elements 0xAAAA/0xBBBB/0xCCCC:
  - Addresses 0x0FFE, 0x1000, 0x1002.
  - written_data 0xAAAA0000, 0xBBBB0000, 0xCCCC0000.
  - resp_valid at T+7.
- Load ONE_BYTE, addr 0x1FFFF, length 2 -> addresses 0x1FFFF then 0x00000 (wrap); each slot = mem_data[31:24] zero-extended.
- length=0 or data_type=3'b111 -> no memory traffic; resp_valid at T+1, resp_error 0 / 1 respectively.
- With DATA_MEM_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_status stuck at MEM_RESTING -> DONE after 4 WAIT cycles, resp_valid=1, resp_error=1.
